// File: rtl/operand_load_ctrl_if.sv
`timescale 1ns/1ps
// Byte-stream side (UART receive, datapath done) and operand-memory side of
// the operand load controller, grouped as one bundle.
interface operand_load_ctrl_if;
  logic [7:0] Rx_Byte_in;
  logic       Rx_Valid_in;
  logic       Alu_Done_in;
  logic [7:0] Rx_Byte_out;
  logic       Load_MSB_a_en_out;
  logic       Load_LSB_a_en_out;
  logic       Load_MSB_b_en_out;
  logic       Load_LSB_b_en_out;
  logic [7:0] Opcode_out;
  logic       Start_out;
  logic       Busy_out;
  logic       Timeout_err_out;
  logic       Overrun_err_out;

  modport slave (
    input  Rx_Byte_in, Rx_Valid_in, Alu_Done_in,
    output Rx_Byte_out, Load_MSB_a_en_out, Load_LSB_a_en_out,
           Load_MSB_b_en_out, Load_LSB_b_en_out, Opcode_out,
           Start_out, Busy_out, Timeout_err_out, Overrun_err_out
  );

  modport master (
    output Rx_Byte_in, Rx_Valid_in, Alu_Done_in,
    input  Rx_Byte_out, Load_MSB_a_en_out, Load_LSB_a_en_out,
           Load_MSB_b_en_out, Load_LSB_b_en_out, Opcode_out,
           Start_out, Busy_out, Timeout_err_out, Overrun_err_out
  );
endinterface

// File: rtl/operand_load_ctrl.sv
`timescale 1ns/1ps
// Parses 5-byte command frames (opcode, aMSB, aLSB, bMSB, bLSB) into operand
// load strobes, starts the datapath and waits for completion.
module operand_load_ctrl #(
  parameter int TIMEOUT_CYCLES = 100000,
  parameter int CNT_W          = 17
) (
  input  logic                CLK,
  input  logic                RST,
  operand_load_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, GET_AMSB, GET_ALSB, GET_BMSB, GET_BLSB, START, WAIT_DONE
  } state_t;

  // The counter never holds TIMEOUT_CYCLES itself: abort fires on the cycle
  // the increment would reach it.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       byte_q, byte_d;
  logic [7:0]       opcode_q, opcode_d;
  logic [3:0]       en_q, en_d;
  logic             start_q, start_d;
  logic             tmo_q, tmo_d;
  logic             ovr_q, ovr_d;
  logic             busy_q, busy_d;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      byte_q   <= 8'h00;
      opcode_q <= 8'h00;
      en_q     <= 4'b0000;
      start_q  <= 1'b0;
      tmo_q    <= 1'b0;
      ovr_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      byte_q   <= byte_d;
      opcode_q <= opcode_d;
      en_q     <= en_d;
      start_q  <= start_d;
      tmo_q    <= tmo_d;
      ovr_q    <= ovr_d;
      busy_q   <= busy_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    byte_d   = byte_q;
    opcode_d = opcode_q;
    en_d     = 4'b0000;
    start_d  = 1'b0;
    tmo_d    = 1'b0;
    ovr_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.Rx_Valid_in) begin
          opcode_d = bus.Rx_Byte_in;
          cnt_d    = '0;
          state_d  = GET_AMSB;
        end
      end

      GET_AMSB, GET_ALSB, GET_BMSB, GET_BLSB: begin
        if (bus.Rx_Valid_in) begin
          // Enable bit order: {a MSB, a LSB, b MSB, b LSB}
          byte_d = bus.Rx_Byte_in;
          cnt_d  = '0;
          unique case (state_q)
            GET_AMSB: begin en_d = 4'b1000; state_d = GET_ALSB; end
            GET_ALSB: begin en_d = 4'b0100; state_d = GET_BMSB; end
            GET_BMSB: begin en_d = 4'b0010; state_d = GET_BLSB; end
            default:  begin en_d = 4'b0001; state_d = START;    end
          endcase
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          tmo_d   = 1'b1;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      START: begin
        start_d = 1'b1;
        ovr_d   = bus.Rx_Valid_in;
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        ovr_d = bus.Rx_Valid_in;
        if (bus.Alu_Done_in) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  assign bus.Rx_Byte_out       = byte_q;
  assign bus.Load_MSB_a_en_out = en_q[3];
  assign bus.Load_LSB_a_en_out = en_q[2];
  assign bus.Load_MSB_b_en_out = en_q[1];
  assign bus.Load_LSB_b_en_out = en_q[0];
  assign bus.Opcode_out        = opcode_q;
  assign bus.Start_out         = start_q;
  assign bus.Busy_out          = busy_q;
  assign bus.Timeout_err_out   = tmo_q;
  assign bus.Overrun_err_out   = ovr_q;

endmodule

// File: tb/tb_operand_load_ctrl.sv
`timescale 1ns/1ps
// Directed bench for operand_load_ctrl: a long-timeout instance for frame
// parsing/overrun/reset and a TIMEOUT_CYCLES=8 instance for abort behaviour.
module tb_operand_load_ctrl;

  typedef struct packed {
    logic        d;
    logic [3:0]  en;
    logic        st;
    logic        tmo;
    logic        ovr;
    logic [7:0]  rb;
    logic [7:0]  opc;
    logic        busy;
    logic [31:0] cyc;
  } ev_t;

  logic        CLK;
  logic        RST;
  logic [7:0]  rx_byte;
  logic        rx_valid;
  logic        alu_done;
  logic        sel;
  logic        end_req;
  logic [31:0] cyc;
  int          n_cmp;
  int          n_err;
  ev_t         exp_q[$];
  ev_t         lvl_q[$];
  ev_t         o [2];

  operand_load_ctrl_if if0();
  operand_load_ctrl_if if1();

  assign if0.Rx_Byte_in  = rx_byte;
  assign if0.Rx_Valid_in = rx_valid & ~sel;
  assign if0.Alu_Done_in = alu_done & ~sel;
  assign if1.Rx_Byte_in  = rx_byte;
  assign if1.Rx_Valid_in = rx_valid & sel;
  assign if1.Alu_Done_in = alu_done & sel;

  operand_load_ctrl #(.TIMEOUT_CYCLES(100000), .CNT_W(17)) dut_long (
    .CLK(CLK), .RST(RST), .bus(if0.slave));
  operand_load_ctrl #(.TIMEOUT_CYCLES(8), .CNT_W(4)) dut_short (
    .CLK(CLK), .RST(RST), .bus(if1.slave));

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial cyc = 32'd0;
  always @(posedge CLK) cyc <= cyc + 32'd1;

  function automatic ev_t mk(input logic d, input logic [3:0] en, input logic st,
                             input logic tmo, input logic ovr, input logic [7:0] rb,
                             input logic [7:0] opc, input logic busy, input logic [31:0] c);
    ev_t e;
    e.d = d; e.en = en; e.st = st; e.tmo = tmo; e.ovr = ovr;
    e.rb = rb; e.opc = opc; e.busy = busy; e.cyc = c;
    return e;
  endfunction

  function automatic string fmt(input ev_t e);
    return $sformatf("dut%0d en=%b st=%b tmo=%b ovr=%b byte=%h opc=%h busy=%b cyc=%0d",
                     e.d, e.en, e.st, e.tmo, e.ovr, e.rb, e.opc, e.busy, e.cyc);
  endfunction

  // ---------------- scoreboard / monitor ----------------
  task automatic check_event(input ev_t ob);
    ev_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_event: got %s, required no event", fmt(ob));
    end else begin
      e = exp_q.pop_front();
      if (ob !== e) begin
        n_err++;
        $display("FAIL event: got %s, required %s", fmt(ob), fmt(e));
      end
    end
  endtask

  task automatic check_level(input ev_t ob, input ev_t e);
    n_cmp++;
    if (ob !== e) begin
      n_err++;
      $display("FAIL level: got %s, required %s", fmt(ob), fmt(e));
    end
  endtask

  always @(negedge CLK) begin
    ev_t e;
    o[0] = mk(1'b0, {if0.Load_MSB_a_en_out, if0.Load_LSB_a_en_out, if0.Load_MSB_b_en_out,
              if0.Load_LSB_b_en_out}, if0.Start_out, if0.Timeout_err_out, if0.Overrun_err_out,
              if0.Rx_Byte_out, if0.Opcode_out, if0.Busy_out, cyc);
    o[1] = mk(1'b1, {if1.Load_MSB_a_en_out, if1.Load_LSB_a_en_out, if1.Load_MSB_b_en_out,
              if1.Load_LSB_b_en_out}, if1.Start_out, if1.Timeout_err_out, if1.Overrun_err_out,
              if1.Rx_Byte_out, if1.Opcode_out, if1.Busy_out, cyc);
    for (int d = 0; d < 2; d++) begin
      if (o[d].en != 4'b0000 || o[d].st || o[d].tmo || o[d].ovr) check_event(o[d]);
    end
    while (lvl_q.size() != 0 && lvl_q[0].cyc <= cyc) begin
      e = lvl_q.pop_front();
      check_level(o[e.d], e);
    end
    if (end_req) begin
      while (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n_cmp++;
        n_err++;
        $display("FAIL missing_event: got nothing, required %s", fmt(e));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  // ---------------- stimulus ----------------
  task automatic push(input logic d, input logic [3:0] en, input logic st, input logic tmo,
                      input logic ovr, input logic [7:0] rb, input logic [7:0] opc,
                      input logic busy, input logic [31:0] c);
    exp_q.push_back(mk(d, en, st, tmo, ovr, rb, opc, busy, c));
  endtask

  // Expected snapshot of one instance in the current cycle
  task automatic lvl(input logic d, input logic [3:0] en, input logic [7:0] rb,
                     input logic [7:0] opc, input logic busy);
    lvl_q.push_back(mk(d, en, 1'b0, 1'b0, 1'b0, rb, opc, busy, cyc));
  endtask

  task automatic step(input logic v, input logic [7:0] b, input logic dn);
    rx_valid = v;
    rx_byte  = b;
    alu_done = dn;
    @(posedge CLK);
    #1;
    rx_valid = 1'b0;
    alu_done = 1'b0;
  endtask

  task automatic idle(input int k);
    for (int i = 0; i < k; i++) step(1'b0, 8'h00, 1'b0);
  endtask

  task automatic frame_b2b(input logic d, input logic [7:0] op, input logic [7:0] a1,
                           input logic [7:0] a0, input logic [7:0] b1, input logic [7:0] b0);
    logic [31:0] n;
    n = cyc;
    push(d, 4'b1000, 1'b0, 1'b0, 1'b0, a1, op, 1'b1, n + 32'd2);
    push(d, 4'b0100, 1'b0, 1'b0, 1'b0, a0, op, 1'b1, n + 32'd3);
    push(d, 4'b0010, 1'b0, 1'b0, 1'b0, b1, op, 1'b1, n + 32'd4);
    push(d, 4'b0001, 1'b0, 1'b0, 1'b0, b0, op, 1'b1, n + 32'd5);
    push(d, 4'b0000, 1'b1, 1'b0, 1'b0, b0, op, 1'b1, n + 32'd6);
    step(1'b1, op, 1'b0);
    step(1'b1, a1, 1'b0);
    step(1'b1, a0, 1'b0);
    step(1'b1, b1, 1'b0);
    step(1'b1, b0, 1'b0);
  endtask

  logic [7:0] gbytes [4];
  logic [3:0] gens   [4];

  initial begin
    logic [31:0] n;
    RST = 1'b0; rx_byte = 8'h00; rx_valid = 1'b0; alu_done = 1'b0;
    sel = 1'b0; end_req = 1'b0; n_cmp = 0; n_err = 0;
    gbytes[0] = 8'h12; gbytes[1] = 8'h34; gbytes[2] = 8'hAB; gbytes[3] = 8'hCD;
    gens[0] = 4'b1000; gens[1] = 4'b0100; gens[2] = 4'b0010; gens[3] = 4'b0001;

    repeat (2) @(posedge CLK);
    #1;
    lvl(1'b0, 4'b0000, 8'h00, 8'h00, 1'b0);
    lvl(1'b1, 4'b0000, 8'h00, 8'h00, 1'b0);
    @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(2);

    // Frame with 10-cycle gaps
    step(1'b1, 8'h03, 1'b0);
    lvl(1'b0, 4'b0000, 8'h00, 8'h03, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(10);
      push(1'b0, gens[i], 1'b0, 1'b0, 1'b0, gbytes[i], 8'h03, 1'b1, cyc + 32'd1);
      if (i == 3) push(1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 8'hCD, 8'h03, 1'b1, cyc + 32'd2);
      step(1'b1, gbytes[i], 1'b0);
    end
    idle(5);
    lvl(1'b0, 4'b0000, 8'hCD, 8'h03, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    lvl(1'b0, 4'b0000, 8'hCD, 8'h03, 1'b0);

    // Same frame back-to-back
    frame_b2b(1'b0, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD);
    idle(3);
    step(1'b0, 8'h00, 1'b1);
    lvl(1'b0, 4'b0000, 8'hCD, 8'h03, 1'b0);

    // Overrun in WAIT_DONE, then byte coincident with done
    frame_b2b(1'b0, 8'h05, 8'h01, 8'h02, 8'h03, 8'h04);
    idle(2);
    push(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h04, 8'h05, 1'b1, cyc + 32'd1);
    step(1'b1, 8'h77, 1'b0);
    idle(2);
    lvl(1'b0, 4'b0000, 8'h04, 8'h05, 1'b1);
    push(1'b0, 4'b0000, 1'b0, 1'b0, 1'b1, 8'h04, 8'h05, 1'b0, cyc + 32'd1);
    step(1'b1, 8'h77, 1'b1);
    idle(1);
    lvl(1'b0, 4'b0000, 8'h04, 8'h05, 1'b0);

    // Reset after the a LSB byte
    n = cyc;
    push(1'b0, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h11, 8'h09, 1'b1, n + 32'd2);
    push(1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 8'h22, 8'h09, 1'b1, n + 32'd3);
    step(1'b1, 8'h09, 1'b0);
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    idle(1);
    RST = 1'b0;
    #1;
    lvl(1'b0, 4'b0000, 8'h00, 8'h00, 1'b0);
    lvl(1'b1, 4'b0000, 8'h00, 8'h00, 1'b0);
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    idle(1);
    frame_b2b(1'b0, 8'h04, 8'h00, 8'h01, 8'h00, 8'h02);
    idle(3);
    step(1'b0, 8'h00, 1'b1);
    lvl(1'b0, 4'b0000, 8'h02, 8'h04, 1'b0);

    // Timeout on the short instance: 0x01, 0x55, then silence
    sel = 1'b1;
    idle(1);
    n = cyc;
    push(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h55, 8'h01, 1'b1, n + 32'd2);
    push(1'b1, 4'b0000, 1'b0, 1'b1, 1'b0, 8'h55, 8'h01, 1'b0, n + 32'd10);
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    idle(7);
    lvl(1'b1, 4'b0000, 8'h55, 8'h01, 1'b1);
    idle(5);
    lvl(1'b1, 4'b0000, 8'h55, 8'h01, 1'b0);
    frame_b2b(1'b1, 8'h02, 8'hA1, 8'hA2, 8'hB1, 8'hB2);
    idle(3);
    step(1'b0, 8'h00, 1'b1);
    idle(1);

    // Bytes landing exactly on the timeout cycle are accepted
    step(1'b1, 8'h06, 1'b0);
    idle(7);
    push(1'b1, 4'b1000, 1'b0, 1'b0, 1'b0, 8'h10, 8'h06, 1'b1, cyc + 32'd1);
    step(1'b1, 8'h10, 1'b0);
    idle(7);
    push(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 8'h20, 8'h06, 1'b1, cyc + 32'd1);
    step(1'b1, 8'h20, 1'b0);
    push(1'b1, 4'b0010, 1'b0, 1'b0, 1'b0, 8'h30, 8'h06, 1'b1, cyc + 32'd1);
    step(1'b1, 8'h30, 1'b0);
    push(1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 8'h40, 8'h06, 1'b1, cyc + 32'd1);
    push(1'b1, 4'b0000, 1'b1, 1'b0, 1'b0, 8'h40, 8'h06, 1'b1, cyc + 32'd2);
    step(1'b1, 8'h40, 1'b0);
    idle(3);
    step(1'b0, 8'h00, 1'b1);
    lvl(1'b1, 4'b0000, 8'h40, 8'h06, 1'b0);
    idle(3);

    end_req = 1'b1;
    repeat (5) @(posedge CLK);
    $display("FAIL summary_not_reached: got no summary, required summary");
    $fatal(1, "monitor did not finish");
  end

endmodule
